// File: rtl/mux_pkg.sv
// Shared width constant and source tag for the two-input round-robin mux and its bench.
package mux_pkg;

  localparam int MUX_W = 8;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/mux_rr_arb_rr_arb2.sv
// Two-requester arbiter: combinational grant plus the round-robin pointer.
// MUX_RR_ARB_FIXED_PRIO_EN makes A always win contention and drops the pointer.
module rr_arb2
  import mux_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

`ifdef MUX_RR_ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{clk, reset, advance};

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  // last holds the most recently granted source; reset to B so A wins first.
  src_e last;

  always_ff @(posedge clk) begin
    if (reset)        last <= SRC_B;
    else if (advance) last <= gnt[1] ? SRC_B : SRC_A;
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == SRC_A) ? 2'b10 : 2'b01;
  end
`endif

endmodule

// File: rtl/mux_rr_arb.sv
// Two-source arbitrated mux into a one-entry registered output stage.
// Build option: MUX_RR_ARB_FIXED_PRIO_EN (A always wins contention).
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int N = MUX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a_i,
  input  logic         a_valid_i,
  output logic         a_ready_o,
  input  logic [N-1:0] b_i,
  input  logic         b_valid_i,
  output logic         b_ready_o,
  output logic [N-1:0] y_o,
  output logic         sel_o,
  output logic         y_valid_o,
  input  logic         y_ready_i
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       load_en;
  logic       accept;

  assign load_en = !y_valid_o || y_ready_i;
  // Masking requests in reset keeps both readies low without touching the pointer.
  assign req     = reset ? 2'b00 : {b_valid_i, a_valid_i};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  assign a_ready_o = load_en && gnt[0];
  assign b_ready_o = load_en && gnt[1];
  assign accept    = a_ready_o || b_ready_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_valid_o <= 1'b0;
      y_o       <= '0;
      sel_o     <= SRC_A;
    end else if (load_en) begin
      y_valid_o <= accept;
      if (accept) begin
        y_o   <= gnt[1] ? b_i : a_i;
        sel_o <= gnt[1];
      end
    end
  end

endmodule
